// File: rtl/fir_chan_sched_pkg.sv
// Shared constants, FSM state type and helpers for the four-channel sample scheduler.
package fir_4mux1_pkg;

    localparam int unsigned NCH    = 4;
    localparam int unsigned GAIN_W = 3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } sched_state_e;

    function automatic logic [1:0] oh2idx(input logic [NCH-1:0] oh);
        oh2idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (oh[i]) begin
                oh2idx = 2'(i);
            end
        end
    endfunction

endpackage

// File: rtl/fir_chan_sched_if.sv
// Channel-side and datapath-side signal bundle of fir_chan_sched.
interface fir_chan_sched_if
    import fir_4mux1_pkg::*;
#(
    parameter int unsigned INBITWIDTH  = 22,
    parameter int unsigned COEBITWIDTH = 16
);

    logic [NCH*INBITWIDTH-1:0] ch_data;
    logic [NCH-1:0]            ch_flag;
    logic                      gain_indicator;
    logic [1:0]                gain_ch;
    logic [COEBITWIDTH-1:0]    gain_param;
    logic                      config_sync;
    logic                      overrun_clr;
    logic [INBITWIDTH-1:0]     datab;
    logic                      datab_flag;
    logic [1:0]                ch_id;
    logic [GAIN_W-1:0]         gain_factor;
    logic                      busy;
    logic [NCH-1:0]            overrun;

    modport master (
        output ch_data, ch_flag, gain_indicator, gain_ch, gain_param, config_sync, overrun_clr,
        input  datab, datab_flag, ch_id, gain_factor, busy, overrun
    );

    modport slave (
        input  ch_data, ch_flag, gain_indicator, gain_ch, gain_param, config_sync, overrun_clr,
        output datab, datab_flag, ch_id, gain_factor, busy, overrun
    );

endinterface

// File: rtl/fir_chan_sched_arb.sv
// Four-way request arbiter: round-robin by default, fixed priority (ch0 highest) when
// FIR_SCHED_PRIO_EN is defined.
module rr_arbiter_4
    import fir_4mux1_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] request,
    input  logic           enable,
    output logic [NCH-1:0] grant
);

`ifdef FIR_SCHED_PRIO_EN
    logic unused_prio;
    assign unused_prio = ^{clk, rst, enable};

    // Isolate the lowest set request bit.
    assign grant = request & (~request + NCH'(1));
`else
    logic [1:0] ptr_q;
    logic [1:0] idx;
    logic       found;

    // Search starts one past the last granted channel.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && request[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 2'd3;
        end else if (enable && |request) begin
            ptr_q <= oh2idx(grant);
        end
    end
`endif

endmodule

// File: rtl/fir_chan_sched.sv
// Schedules four channel sample streams onto one shared datapath with per-channel gains.
// Build option: FIR_SCHED_PRIO_EN selects fixed-priority arbitration.
module fir_chan_sched
    import fir_4mux1_pkg::*;
#(
    parameter int unsigned INBITWIDTH  = 22,
    parameter int unsigned COEBITWIDTH = 16,
    parameter int unsigned SLOT_LEN    = 4
) (
    input logic             clk,
    input logic             rst,
    fir_chan_sched_if.slave bus
);

    sched_state_e          state_q;
    logic [NCH-1:0]        pend_q, pend_d;
    logic [NCH-1:0]        overrun_q, overrun_d;
    logic [INBITWIDTH-1:0] pend_data_q [NCH];
    logic [INBITWIDTH-1:0] pend_data_d [NCH];
    logic [GAIN_W-1:0]     shadow_q [NCH];
    logic [GAIN_W-1:0]     shadow_d [NCH];
    logic [GAIN_W-1:0]     active_q [NCH];
    logic [GAIN_W-1:0]     active_d [NCH];
    logic [1:0]            grant_q;
    logic [NCH-1:0]        grant_oh;
    logic [1:0]            grant_idx;
    logic [3:0]            cnt_q;
    logic [INBITWIDTH-1:0] datab_q;
    logic                  datab_flag_q;
    logic [1:0]            ch_id_q;
    logic [GAIN_W-1:0]     gain_factor_q;
    logic                  busy_q;
    logic                  clearing;
    logic                  unused_gain;

    assign unused_gain = ^bus.gain_param[COEBITWIDTH-1:GAIN_W];

    rr_arbiter_4 u_arb (
        .clk     (clk),
        .rst     (rst),
        .request (pend_q),
        .enable  (state_q == StIdle),
        .grant   (grant_oh)
    );

    assign grant_idx = oh2idx(grant_oh);

    // A new sample during the issuing channel's ISSUE cycle re-arms pend without overrun.
    always_comb begin
        pend_d    = pend_q;
        overrun_d = bus.overrun_clr ? '0 : overrun_q;
        clearing  = 1'b0;
        for (int n = 0; n < NCH; n++) begin
            pend_data_d[n] = pend_data_q[n];
            clearing       = (state_q == StIssue) && (grant_q == 2'(n));
            if (clearing) begin
                pend_d[n] = 1'b0;
            end
            if (bus.ch_flag[n]) begin
                pend_data_d[n] = bus.ch_data[n*INBITWIDTH +: INBITWIDTH];
                pend_d[n]      = 1'b1;
                if (pend_q[n] && !clearing) begin
                    overrun_d[n] = 1'b1;
                end
            end
        end
    end

    // The sync copy sees a same-cycle shadow write.
    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            shadow_d[n] = shadow_q[n];
        end
        if (bus.gain_indicator) begin
            shadow_d[bus.gain_ch] = bus.gain_param[GAIN_W-1:0];
        end
        for (int n = 0; n < NCH; n++) begin
            active_d[n] = bus.config_sync ? shadow_d[n] : active_q[n];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            pend_q        <= '0;
            overrun_q     <= '0;
            grant_q       <= '0;
            cnt_q         <= '0;
            datab_q       <= '0;
            datab_flag_q  <= 1'b0;
            ch_id_q       <= '0;
            gain_factor_q <= '0;
            busy_q        <= 1'b0;
            for (int n = 0; n < NCH; n++) begin
                pend_data_q[n] <= '0;
                shadow_q[n]    <= '0;
                active_q[n]    <= '0;
            end
        end else begin
            pend_q       <= pend_d;
            overrun_q    <= overrun_d;
            datab_flag_q <= 1'b0;
            for (int n = 0; n < NCH; n++) begin
                pend_data_q[n] <= pend_data_d[n];
                shadow_q[n]    <= shadow_d[n];
                active_q[n]    <= active_d[n];
            end
            case (state_q)
                StIdle: begin
                    if (|pend_q) begin
                        state_q       <= StIssue;
                        grant_q       <= grant_idx;
                        datab_q       <= pend_data_d[grant_idx];
                        ch_id_q       <= grant_idx;
                        gain_factor_q <= active_d[grant_idx];
                        datab_flag_q  <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                    cnt_q   <= 4'(SLOT_LEN - 1);
                end
                StWait: begin
                    if (cnt_q <= 4'd1) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.datab       = datab_q;
    assign bus.datab_flag  = datab_flag_q;
    assign bus.ch_id       = ch_id_q;
    assign bus.gain_factor = gain_factor_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_fir_chan_sched.sv
// Scoreboard bench for fir_chan_sched: a cycle-level reference model predicts issues and flags,
// a negedge monitor compares every DUT presentation against it.
module tb_fir_chan_sched;
    import fir_4mux1_pkg::*;

    localparam int unsigned INBITWIDTH  = 22;
    localparam int unsigned COEBITWIDTH = 16;
    localparam int unsigned SLOT_LEN    = 4;

    typedef struct {
        int                    ch;
        logic [INBITWIDTH-1:0] data;
        logic [2:0]            gain;
        int                    cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fir_chan_sched_if #(.INBITWIDTH(INBITWIDTH), .COEBITWIDTH(COEBITWIDTH)) bus ();

    fir_chan_sched #(
        .INBITWIDTH  (INBITWIDTH),
        .COEBITWIDTH (COEBITWIDTH),
        .SLOT_LEN    (SLOT_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_issue = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model state
    exp_t                  q[$];
    bit   [3:0]            m_pend;
    logic [INBITWIDTH-1:0] m_data [4];
    logic [2:0]            m_sh [4];
    logic [2:0]            m_act [4];
    bit   [3:0]            m_ovr;
    int                    m_last;
    int                    m_wait;
    int                    m_issuing;
    int                    cyc;

    function automatic int pick(input bit [3:0] p, input int last);
`ifdef FIR_SCHED_PRIO_EN
        for (int i = 0; i < 4; i++) if (p[i]) return i;
`else
        for (int k = 1; k <= 4; k++) if (p[(last + k) % 4]) return (last + k) % 4;
`endif
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_pend = '0; m_ovr = '0; m_last = 3; m_wait = 0; m_issuing = -1; cyc = 0;
            for (int n = 0; n < 4; n++) begin
                m_data[n] = '0; m_sh[n] = '0; m_act[n] = '0;
            end
        end else begin
            bit [3:0] p0;
            int       iss;
            cyc++;
            p0        = m_pend;
            iss       = m_issuing;
            m_issuing = -1;
            if (bus.overrun_clr) m_ovr = '0;
            for (int n = 0; n < 4; n++) begin
                if (bus.ch_flag[n]) begin
                    m_data[n] = bus.ch_data[n*INBITWIDTH +: INBITWIDTH];
                    if (p0[n] && iss != n) m_ovr[n] = 1'b1;
                    m_pend[n] = 1'b1;
                end else if (iss == n) begin
                    m_pend[n] = 1'b0;
                end
            end
            if (bus.gain_indicator) m_sh[bus.gain_ch] = bus.gain_param[2:0];
            if (bus.config_sync) for (int n = 0; n < 4; n++) m_act[n] = m_sh[n];
            if (m_wait > 0) begin
                m_wait--;
            end else if (p0 != 0) begin
                exp_t e;
                e.ch   = pick(p0, m_last);
                e.data = m_data[e.ch];
                e.gain = m_act[e.ch];
                e.cyc  = cyc;
                q.push_back(e);
                m_last    = e.ch;
                m_issuing = e.ch;
                m_wait    = SLOT_LEN;
            end
        end
    end

    // Monitor
    logic [INBITWIDTH-1:0] h_data;
    logic [1:0]            h_ch;
    logic [2:0]            h_gain;

    always @(negedge clk) begin
        if (!rst) begin
            h_data = '0; h_ch = '0; h_gain = '0;
            chk("rst_datab", 64'(bus.datab), 64'd0);
            chk("rst_flag", 64'(bus.datab_flag), 64'd0);
            chk("rst_ch_id", 64'(bus.ch_id), 64'd0);
            chk("rst_gain", 64'(bus.gain_factor), 64'd0);
            chk("rst_busy", 64'(bus.busy), 64'd0);
            chk("rst_overrun", 64'(bus.overrun), 64'd0);
        end else begin
            bit exp_now;
            exp_now = (q.size() > 0) && (q[0].cyc == cyc);
            chk("issue_strobe", 64'(bus.datab_flag), 64'(exp_now));
            if (exp_now) begin
                exp_t e;
                e = q.pop_front();
                n_issue++;
                h_data = e.data; h_ch = 2'(e.ch); h_gain = e.gain;
            end
            chk("datab", 64'(bus.datab), 64'(h_data));
            chk("ch_id", 64'(bus.ch_id), 64'(h_ch));
            chk("gain_factor", 64'(bus.gain_factor), 64'(h_gain));
            chk("busy", 64'(bus.busy), 64'(m_wait > 0));
            chk("overrun", 64'(bus.overrun), 64'(m_ovr));
        end
    end

    task automatic drive(input logic [3:0] flag, input logic gi = 1'b0, input logic [1:0] gch = 2'd0,
                         input logic [15:0] gp = 16'd0, input logic sync = 1'b0,
                         input logic clr = 1'b0);
        for (int n = 0; n < 4; n++) bus.ch_data[n*INBITWIDTH +: INBITWIDTH] = INBITWIDTH'($urandom);
        bus.ch_flag        = flag;
        bus.gain_indicator = gi;
        bus.gain_ch        = gch;
        bus.gain_param     = gp;
        bus.config_sync    = sync;
        bus.overrun_clr    = clr;
        @(posedge clk);
        #1;
        bus.ch_flag = '0; bus.gain_indicator = 1'b0; bus.config_sync = 1'b0;
        bus.overrun_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(4'b0000);
    endtask

    initial begin
        bus.ch_data = '0; bus.ch_flag = '0; bus.gain_indicator = 1'b0; bus.gain_ch = '0;
        bus.gain_param = '0; bus.config_sync = 1'b0; bus.overrun_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(2);
        // All four at once: round-robin from ch0, five cycles apart
        drive(4'b1111);
        idle(25);
        // Overrun on ch2 while busy, then clear
        drive(4'b0001);
        drive(4'b0100);
        idle(1);
        drive(4'b0100);
        idle(15);
        drive(4'b0000, 1'b0, 2'd0, 16'd0, 1'b0, 1'b1);
        idle(2);
        // Gain load, sync, then issue on ch1
        drive(4'b0000, 1'b1, 2'd1, 16'h0005);
        idle(1);
        drive(4'b0000, 1'b0, 2'd0, 16'd0, 1'b1);
        drive(4'b0010);
        idle(8);
        // Gain change during WAIT; same-cycle shadow write and sync
        drive(4'b1000);
        idle(2);
        drive(4'b0000, 1'b1, 2'd3, 16'hfff2, 1'b1);
        idle(6);
        drive(4'b1000);
        idle(8);
        // Overrun event and clear in the same cycle
        drive(4'b0010);
        drive(4'b0010, 1'b0, 2'd0, 16'd0, 1'b0, 1'b1);
        idle(12);
        // Reset during WAIT with pending work
        drive(4'b0001);
        idle(1);
        drive(4'b0110);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        idle(20);
        // Random traffic
        for (int i = 0; i < 800; i++) begin
            drive(4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)),
                  ($urandom_range(0, 9) == 0), 2'($urandom), 16'($urandom),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
        end
        idle(20);
        chk("queue_drained", 64'(q.size()), 64'd0);
        chk("enough_issues", 64'(n_issue >= 20), 64'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_chan_sched.md
FIR_CHAN_SCHED -- requirements
Module: fir_chan_sched

Interface
REQ-001 Parameter INBITWIDTH, default 22, width of each channel sample.
REQ-002 Parameter COEBITWIDTH, default 16, width of gain_param.
REQ-003 Parameter SLOT_LEN, default 4, shared-datapath cycles per issued sample, legal range 2..15.
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 ch_data  input  4*INBITWIDTH  channel n sample in bits [n*INBITWIDTH +: INBITWIDTH].
REQ-007 ch_flag  input  4  per-channel one-cycle sample-valid strobe.
REQ-008 gain_indicator  input  1  load gain_param[2:0] into shadow[gain_ch].
REQ-009 gain_ch  input  2  target channel for gain_indicator.
REQ-010 gain_param  input  COEBITWIDTH  gain word; only bits [2:0] are used.
REQ-011 config_sync  input  1  copy all four shadows to the active gain registers.
REQ-012 overrun_clr  input  1  clear all overrun bits.
REQ-013 datab  output  INBITWIDTH  sample issued to the shared datapath.
REQ-014 datab_flag  output  1  one-cycle issue strobe.
REQ-015 ch_id  output  2  channel of the current or last issue.
REQ-016 gain_factor  output  3  active gain of the issued channel, held for the slot.
REQ-017 busy  output  1  high while the FSM is in ISSUE or WAIT.
REQ-018 overrun  output  4  sticky per-channel overrun bits.

Function
REQ-019 A ch_flag[n] pulse shall capture ch_data[n] into pend_data[n] and set pend[n].
REQ-020 The FSM shall have states IDLE, ISSUE and WAIT.
REQ-021 IDLE: if any pend bit is set, grant one channel and go to ISSUE next cycle; otherwise stay in IDLE.
REQ-022 Arbitration shall be round-robin, searching from the channel after the last grant; after reset the search starts at channel 0.
REQ-023 ISSUE lasts one cycle: datab=pend_data[g], datab_flag=1, ch_id=g, gain_factor=active[g]; pend[g] is cleared.
REQ-024 WAIT lasts SLOT_LEN-1 cycles, counted by a 4-bit down-counter, then the FSM returns to IDLE.
REQ-025 The issue rate shall be at most one sample per SLOT_LEN+1 cycles.
REQ-026 datab, ch_id and gain_factor shall hold their values until the next ISSUE; datab_flag is 0 outside ISSUE.
REQ-027 ch_flag[n] while pend[n]=1 and not being cleared: overwrite pend_data[n] and set overrun[n].
REQ-028 ch_flag[n] in the same cycle as ISSUE of channel n: capture the new sample, leave pend[n]=1, no overrun.
REQ-029 gain_indicator and config_sync in the same cycle: the shadow is updated first, then the copy uses the updated value.
REQ-030 config_sync during WAIT updates the active registers immediately; the gain_factor output of the issue in flight is unchanged.
REQ-031 overrun_clr and a new overrun event in the same cycle: the overrun bit is set (set wins).

Reset
REQ-032 rst low asynchronously forces state=IDLE, pend=0, pend_data=0, shadows=0, active=0, counter=0, round-robin pointer=3, datab=0, datab_flag=0, ch_id=0, gain_factor=0, busy=0, overrun=0.
REQ-033 Reset asserted mid-slot shall abort the slot; pending samples are discarded.

Configuration
REQ-034 When macro FIR_SCHED_PRIO_EN is defined, arbitration is fixed priority (channel 0 highest, channel 3 lowest); when it is undefined, round-robin per REQ-022 applies.

Structure
REQ-035 Package fir_4mux1_pkg holds NCH=4, the state enum (IDLE/ISSUE/WAIT) and the gain width of 3.
REQ-036 Arbitration is a sub-module rr_arbiter_4: request[3:0], enable, pointer update, and a one-hot grant; the FIR_SCHED_PRIO_EN switch is implemented inside it.

Verification
REQ-037 ch_flag=4'b1111 once, SLOT_LEN=4 -> issues ch0,1,2,3, datab_flag pulses 5 cycles apart.
REQ-038 ch_flag[2] pulsed twice 2 cycles apart while busy -> overrun[2]=1, the second sample is issued; overrun_clr -> 0.
REQ-039 gain_indicator gain_ch=1 gain_param=0x0005, then config_sync, then ch_flag[1] -> gain_factor=5 at issue.
REQ-040 config_sync with a new gain during WAIT -> gain_factor holds until the next ISSUE.
REQ-041 rst low during WAIT with pend=4'b0110 -> all outputs 0; nothing is issued after release.
REQ-042 With FIR_SCHED_PRIO_EN defined, ch0 and ch3 requesting continuously -> only ch0 is issued.
